// File: rtl/mask_tile_pooler.sv
// Tile pooler: captures a binary mask frame and reports per-tile
// set-bit counts and occupancy flags in raster order.
module mask_tile_pooler #(
  parameter int HEIGHT = 32,
  parameter int LENGTH = 32,
  parameter int TILE   = 4,
  parameter int THRESH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [HEIGHT-1:0][LENGTH-1:0]       mask,
  output logic                                busy,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_bit,
  output logic [$clog2(TILE*TILE+1)-1:0]      out_count,
  output logic [$clog2(HEIGHT/TILE)-1:0]      out_row,
  output logic [$clog2(LENGTH/TILE)-1:0]      out_col,
  output logic                                out_last,
  output logic                                done
);

  localparam int TR = HEIGHT / TILE;
  localparam int TC = LENGTH / TILE;
  localparam int NW = $clog2(TILE*TILE+1);
  localparam int RW = $clog2(TR);
  localparam int CW = $clog2(TC);
  localparam int KW = (TILE > 1) ? $clog2(TILE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    EMIT,
    FIN
  } state_t;

  state_t                        state_q, state_d;
  logic [HEIGHT-1:0][LENGTH-1:0] frame_q, frame_d;
  logic [RW-1:0]                 row_q, row_d;
  logic [CW-1:0]                 col_q, col_d;
  logic [KW-1:0]                 k_q, k_d;
  logic [NW-1:0]                 acc_q, acc_d;

  int                            rix;
  logic [LENGTH-1:0]             line;
  logic [TILE-1:0]               seg;
  logic [NW-1:0]                 pc;
  logic                          last_tile;

  assign last_tile = (row_q == RW'(TR-1)) && (col_q == CW'(TC-1));

  // Popcount of the current pixel row inside the current tile
  always_comb begin
    rix  = int'(row_q) * TILE + int'(k_q);
    line = '0;
    seg  = '0;
    pc   = '0;
    for (int r = 0; r < HEIGHT; r++)
      if (r == rix) line = frame_q[r];
    for (int c = 0; c < TC; c++)
      if (c == int'(col_q)) seg = line[c*TILE +: TILE];
    for (int i = 0; i < TILE; i++)
      pc = pc + NW'(seg[i]);
  end

  // Next-state logic: capture, row accumulation, handshake, finish
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          frame_d = mask;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        acc_d = acc_q + pc;
        if (k_q == KW'(TILE-1)) begin
          k_d     = '0;
          state_d = EMIT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_tile) begin
            state_d = FIN;
          end else begin
            acc_d   = '0;
            k_d     = '0;
            state_d = COUNT;
            if (col_q == CW'(TC-1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_count = acc_q;
  assign out_bit   = out_valid && (acc_q >= NW'(THRESH));
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = out_valid && last_tile;
  assign done      = (state_q == FIN);

endmodule

// File: tb/tb_mask_tile_pooler.sv
// Scoreboard bench for mask_tile_pooler: expected tiles are queued
// from a reference model when a frame starts and popped on handshake.
module tb_mask_tile_pooler;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [31:0][31:0]   mask;
  logic                busy;
  logic                out_valid;
  logic                out_ready;
  logic                out_bit;
  logic [4:0]          out_count;
  logic [2:0]          out_row;
  logic [2:0]          out_col;
  logic                out_last;
  logic                done;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic [4:0] cnt;
    logic       bt;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mask_tile_pooler dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mask      (mask),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_count (out_count),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .done      (done)
  );

  wire exp_t obs = '{out_row, out_col, out_count, out_bit, out_last};

  task automatic build_expected(input logic [31:0][31:0] m);
    exp_t e;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        e.row  = 3'(r);
        e.col  = 3'(c);
        e.cnt  = '0;
        for (int k = 0; k < 4; k++)
          for (int j = 0; j < 4; j++)
            e.cnt = e.cnt + 5'(m[r*4+k][c*4+j]);
        e.bt   = (e.cnt >= 5'd8);
        e.last = (r == 7) && (c == 7);
        q.push_back(e);
      end
  endtask

  task automatic run_frame(input logic [31:0][31:0] m,
                           input int stall_at,
                           input bit disturb,
                           input string name);
    exp_t e;
    exp_t snap;
    int   n;
    q.delete();
    build_expected(m);
    @(negedge clk);
    mask = m;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mask = ~m;
    for (int t = 0; t < 64; t++) begin
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      n_checks++;
      if (n !== 4) begin
        n_fail++;
        $display("FAIL %s latency tile %0d: got %0d cycles, want 4",
                 name, t, n);
      end
      if (!out_valid) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s timeout tile %0d: out_valid never rose",
                 name, t);
        return;
      end
      e = q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s tile %0d: got r%0d c%0d n%0d b%0d l%0d, want r%0d c%0d n%0d b%0d l%0d",
                 name, t, obs.row, obs.col, obs.cnt, obs.bt, obs.last,
                 e.row, e.col, e.cnt, e.bt, e.last);
      end
      n_checks++;
      if ({busy, done} !== 2'b10) begin
        n_fail++;
        $display("FAIL %s busy/done tile %0d: got %b%b, want 10",
                 name, t, busy, done);
      end
      if (t == stall_at) begin
        out_ready = 1'b0;
        snap = obs;
        repeat (10) begin
          if (disturb) begin
            for (int i = 0; i < 32; i++) mask[i] = $urandom;
            start = 1'b1;
          end
          @(negedge clk);
          start = 1'b0;
          n_checks++;
          if (obs !== snap || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s stall: got %h v%b, want %h v1",
                     name, obs, out_valid, snap);
          end
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done pulse: got %b, want 1", name, done);
    end
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s after done: got done%b busy%b, want 00",
               name, done, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    mask = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, out_valid, out_last, done, out_bit, out_count,
         out_row, out_col} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got %b%b%b%b%b n%0d r%0d c%0d, want all 0",
               busy, out_valid, out_last, done, out_bit, out_count,
               out_row, out_col);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset priority: got busy %b, want 0", busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [31:0][31:0] m;
    bit found = 0;
    for (int i = 0; i < 32; i++) m[i] = $urandom;
    @(negedge clk);
    mask = m;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 1000 && !found; n++) begin
      if (out_valid && out_row == 3'd3 && out_col == 3'd1) begin
        found = 1;
        out_ready = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL midreset reach: tile (3,1) not seen, want seen");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if ({busy, out_valid, out_last, done, out_bit, out_count,
         out_row, out_col} !== '0) begin
      n_fail++;
      $display("FAIL midreset outputs: got %b%b%b%b%b n%0d r%0d c%0d, want all 0",
               busy, out_valid, out_last, done, out_bit, out_count,
               out_row, out_col);
    end
    repeat (6) begin
      @(negedge clk);
      n_checks++;
      if ({done, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL midreset idle: got done%b busy%b, want 00",
                 done, busy);
      end
    end
    for (int i = 0; i < 32; i++) m[i] = $urandom;
    run_frame(m, -1, 0, "after_reset");
  endtask

  task automatic test_zero;
    run_frame('0, -1, 0, "zero");
  endtask

  task automatic test_ones;
    logic [31:0][31:0] m;
    m = '1;
    run_frame(m, -1, 0, "ones");
  endtask

  task automatic test_single_tile;
    logic [31:0][31:0] m;
    m = '0;
    for (int r = 8; r < 12; r++)
      for (int c = 20; c < 24; c++) m[r][c] = 1'b1;
    run_frame(m, -1, 0, "tile25");
  endtask

  task automatic test_thresh;
    logic [31:0][31:0] m;
    m = '0;
    m[0][3:0] = 4'hf;
    m[1][2:0] = 3'h7;
    run_frame(m, -1, 0, "thresh7");
    m[1][3] = 1'b1;
    run_frame(m, -1, 0, "thresh8");
  endtask

  task automatic test_stall;
    logic [31:0][31:0] m;
    for (int i = 0; i < 32; i++) m[i] = $urandom;
    run_frame(m, 10, 1, "stall");
  endtask

  task automatic test_back_to_back;
    logic [31:0][31:0] m;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 32; i++) m[i] = $urandom & $urandom;
      run_frame(m, 63, 0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_single_tile();
    test_thresh();
    test_ones();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mask_tile_pooler.md
MASK_TILE_POOLER -- requirements
Module: mask_tile_pooler

Interface
REQ-001 The module SHALL have parameter HEIGHT, default 32, giving the number of mask rows.
REQ-002 The module SHALL have parameter LENGTH, default 32, giving the number of mask columns.
REQ-003 The module SHALL have parameter TILE, default 4, giving the tile edge in pixels; HEIGHT and LENGTH are integer multiples of TILE.
REQ-004 The module SHALL have parameter THRESH, default 8, giving the minimum count of set mask bits that marks a tile as occupied.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all logic updates on the rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port start, input, 1 bit: request to capture mask and begin pooling.
REQ-008 The module SHALL have port mask, input, [HEIGHT-1:0][LENGTH-1:0]: binary frame from the green filter (1 = non-green).
REQ-009 The module SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 The module SHALL have port out_valid, output, 1 bit: a tile result is presented.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The module SHALL have port out_bit, output, 1 bit: tile occupied flag.
REQ-013 The module SHALL have port out_count, output, $clog2(TILE*TILE+1) bits: set-bit count of the tile.
REQ-014 The module SHALL have ports out_row, output, $clog2(HEIGHT/TILE) bits, and out_col, output, $clog2(LENGTH/TILE) bits: tile coordinates.
REQ-015 The module SHALL have port out_last, output, 1 bit: the presented tile is the final tile of the frame.
REQ-016 The module SHALL have port done, output, 1 bit: one-cycle pulse after the final tile is accepted.

Function
REQ-017 The FSM SHALL have states IDLE, COUNT, EMIT, and FIN.
REQ-018 In IDLE, when start=1 at an edge, mask SHALL be registered into an internal frame copy, tile (0,0) SHALL be selected, the accumulator SHALL be cleared, and the FSM SHALL go to COUNT.
REQ-019 start SHALL be ignored in every state except IDLE; mask changes after capture SHALL have no effect on the frame in progress.
REQ-020 In COUNT, each edge SHALL add the popcount of one TILE-bit pixel row of the current tile to the accumulator, top row first; after TILE edges the FSM SHALL go to EMIT.
REQ-021 In EMIT: out_valid=1; out_count = accumulator; out_bit = (accumulator >= THRESH); out_row/out_col = current tile; out_last = 1 only for tile (HEIGHT/TILE-1, LENGTH/TILE-1).
REQ-022 All out_* signals SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 On an edge in EMIT with out_ready=1 and the tile not last, the FSM SHALL advance to the next tile in raster order, clear the accumulator, and go to COUNT.
  - Raster order: column increments first; the column wraps to 0 with a row increment at column LENGTH/TILE-1.
REQ-024 On an edge in EMIT with out_ready=1 and the tile last, the FSM SHALL go to FIN.
REQ-025 FIN SHALL assert done=1 for exactly one cycle, then the FSM SHALL go to IDLE; start sampled in FIN SHALL be ignored.
REQ-026 Latency: out_valid SHALL rise TILE cycles after the start edge, and TILE cycles after each accepting handshake.
REQ-027 out_ready=1 while out_valid=0 SHALL have no effect.
REQ-028 The accumulator SHALL not overflow; its maximum value is TILE*TILE.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, busy=0, out_valid=0, out_last=0, done=0, out_bit=0, out_count=0, out_row=0, out_col=0, and a cleared accumulator, in any state.
REQ-030 rst SHALL take priority over start; a frame interrupted by reset SHALL be abandoned, with no done pulse.

Verification
REQ-031 All-zero mask, start pulse, out_ready held at 1 -> 64 tiles in raster order, each with out_count=0 and out_bit=0; the first out_valid 4 cycles after start; out_last on (7,7); done 1 cycle later.
REQ-032 Mask all ones within tile (2,5) only -> that tile shows out_count=16 and out_bit=1; all other tiles show 0.
REQ-033 Tile (0,0) with exactly 7 set bits, then exactly 8 -> out_bit=0, then out_bit=1 (THRESH boundary).
REQ-034 out_ready held at 0 for 10 cycles during EMIT while mask changes and start pulses -> outputs stable, no restart, and the frame result is unchanged.
REQ-035 rst asserted in the middle of the frame, at tile (3,1) -> next cycle in IDLE with all outputs zero and no done pulse; a new start runs a full 64-tile frame correctly.
